// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronised rx, mid-bit sampling, optional parity,
// stop check, and a valid/ready holding register for the received byte.
// state  | meaning
// IDLE   | waiting for a falling edge on rxs while armed
// START  | confirming the start bit at half a bit period
// DATA   | sampling 8 data bits, LSB first
// PARITY | sampling the parity bit (parity_en only)
// STOP   | sampling the stop bit and reporting the outcome
module uart_rx_os #(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int os_rate    = 16,
  parameter bit parity_en  = 1'b0,
  parameter bit parity_odd = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dout_rx,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       done_rx,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV_RAW = clk_freq / (baud_rate * os_rate);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OSW     = $clog2(os_rate);
  localparam logic [DW-1:0]  DIV_RELOAD = DW'(DIV - 1);
  localparam logic [OSW-1:0] OS_LAST    = OSW'(os_rate - 1);
  localparam logic [OSW-1:0] OS_HALF    = OSW'(os_rate / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   div_cnt;
  logic            tick;
  logic            rx_meta, rxs;
  logic            armed;
  logic [OSW-1:0]  os_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bad;
  logic            samp;

  // Free-running down-counter; tick on terminal count.
  assign tick = (div_cnt == '0);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    samp       = 1'b0;
    case (state)
      IDLE: if (armed && !rxs) state_next = START;
      START: begin
        samp = tick && (os_cnt == OS_HALF);
        if (samp) state_next = rxs ? IDLE : DATA;
      end
      DATA: begin
        samp = tick && (os_cnt == OS_LAST);
        if (samp && bit_cnt == 3'd7) state_next = parity_en ? PARITY : STOP;
      end
      PARITY: begin
        samp = tick && (os_cnt == OS_LAST);
        if (samp) state_next = STOP;
      end
      STOP: begin
        samp = tick && (os_cnt == OS_LAST);
        if (samp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      rx_meta    <= 1'b1;
      rxs        <= 1'b1;
      armed      <= 1'b0;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      dout_rx    <= '0;
      rx_valid   <= 1'b0;
      done_rx    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rxs        <= rx_meta;
      div_cnt    <= tick ? DIV_RELOAD : div_cnt - 1'b1;
      // Arm only on a seen-high line, so a held break cannot retrigger.
      armed      <= (state == IDLE) && rxs;
      os_cnt     <= (state == IDLE || samp) ? '0 : (tick ? os_cnt + 1'b1 : os_cnt);
      done_rx    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;

      if (state == IDLE)            bit_cnt <= '0;
      else if (state == DATA && samp) bit_cnt <= bit_cnt + 1'b1;

      if (state == DATA && samp) shreg <= {rxs, shreg[7:1]};

      if (state == IDLE)               par_bad <= 1'b0;
      else if (state == PARITY && samp) par_bad <= ((^shreg) ^ parity_odd) != rxs;

      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      // A load on the same clk as a consume overrides the clear above.
      if (state == STOP && samp) begin
        if (!rxs)                       frame_err  <= 1'b1;
        else if (par_bad)               parity_err <= 1'b1;
        else if (!rx_valid || rx_ready) begin
          dout_rx  <= shreg;
          rx_valid <= 1'b1;
          done_rx  <= 1'b1;
        end else                        overrun    <= 1'b1;
      end
    end
  end

endmodule
